// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer
//  Description : Instruction fetch / issue controller for the 9-bit IIIXXXYYY
//                processor. Owns the program counter and reads words from a
//                synchronous program memory. Each instruction is presented on
//                DIN with a one-cycle Run pulse, then the block waits for Done.
//                For mvi (opcode 001) the immediate word is prefetched and
//                driven on DIN during execution. A missing Done raises a
//                sticky Fault that only Reset clears.
//
//  Ports       : Clock, Reset       - clock, synchronous active-high reset
//                Enable             - keep fetching while high
//                MemAddr, MemRead   - program memory address / read strobe
//                MemData            - read data, MEM_LATENCY cycles after read
//                DIN, Run, Done     - processor data bus, start pulse, done
//                PC                 - address of next word to fetch
//                Busy, Fault        - activity and sticky timeout flags
//                Retired            - completed instruction count (saturating)
//
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter int ADDR_WIDTH  = 5,
    parameter int MEM_LATENCY = 1,
    parameter int START_ADDR  = 0,
    parameter int TIMEOUT     = 8
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Enable,
    output logic [ADDR_WIDTH-1:0] MemAddr,
    output logic                  MemRead,
    input  logic [8:0]            MemData,
    output logic [8:0]            DIN,
    output logic                  Run,
    input  logic                  Done,
    output logic [ADDR_WIDTH-1:0] PC,
    output logic                  Busy,
    output logic                  Fault,
    output logic [7:0]            Retired
);

    localparam int          TO_W     = $clog2(TIMEOUT + 1);
    localparam logic [2:0]  c_OP_MVI = 3'b001;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH_I = 3'd1,
        S_WAIT_I  = 3'd2,
        S_FETCH_D = 3'd3,
        S_WAIT_D  = 3'd4,
        S_ISSUE   = 3'd5,
        S_EXEC    = 3'd6,
        S_FAULT   = 3'd7
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [1:0]            r_lat;
    logic [TO_W-1:0]       r_to;
    logic [8:0]            r_ir;
    logic [8:0]            r_imm;
    logic [8:0]            r_din;
    logic                  r_memread;
    logic                  r_run;
    logic [7:0]            r_retired;

    logic                  w_lat_last;
    logic [TO_W-1:0]       w_to_inc;
    logic                  w_timeout;
    logic                  w_is_mvi;
    logic                  w_fetching;
    logic [8:0]            w_din_next;

    // Last wait cycle: read data is valid on MemData during this cycle.
    assign w_lat_last = (r_lat == 2'(MEM_LATENCY - 1));
    // r_to holds the number of cycles since the Run cycle; the timeout fires
    // on the edge that would make it TIMEOUT, so Fault shows TIMEOUT cycles
    // after Run and a Done on that last EXEC cycle still wins.
    assign w_to_inc   = r_to + 1'b1;
    assign w_timeout  = (w_to_inc == TO_W'(TIMEOUT));
    assign w_is_mvi   = (r_ir[8:6] == c_OP_MVI);
    assign w_fetching = (r_state == S_FETCH_I) || (r_state == S_FETCH_D);

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (Enable) w_next = S_FETCH_I;
            S_FETCH_I: w_next = S_WAIT_I;
            S_WAIT_I:  if (w_lat_last)
                           w_next = (MemData[8:6] == c_OP_MVI) ? S_FETCH_D : S_ISSUE;
            S_FETCH_D: w_next = S_WAIT_D;
            S_WAIT_D:  if (w_lat_last) w_next = S_ISSUE;
            S_ISSUE:   w_next = S_EXEC;
            S_EXEC: begin
                if (Done)
                    w_next = Enable ? S_FETCH_I : S_IDLE;
                else if (w_timeout)
                    w_next = S_FAULT;
            end
            S_FAULT:   w_next = S_FAULT;
            default:   w_next = S_IDLE;
        endcase
    end

    // DIN is registered, so its value is chosen from the state being entered.
    // Entering ISSUE straight from WAIT_I, the instruction is still on MemData.
    always_comb begin
        w_din_next = 9'd0;
        if (w_next == S_ISSUE)
            w_din_next = (r_state == S_WAIT_I) ? MemData : r_ir;
        else if (w_next == S_EXEC)
            w_din_next = w_is_mvi ? r_imm : 9'd0;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_pc      <= ADDR_WIDTH'(START_ADDR);
            r_lat     <= 2'd0;
            r_to      <= '0;
            r_ir      <= 9'd0;
            r_imm     <= 9'd0;
            r_din     <= 9'd0;
            r_memread <= 1'b0;
            r_run     <= 1'b0;
            r_retired <= 8'd0;
        end else begin
            r_state   <= w_next;
            r_din     <= w_din_next;
            r_memread <= (w_next == S_FETCH_I) || (w_next == S_FETCH_D);
            r_run     <= (w_next == S_ISSUE);

            if (w_fetching)
                r_pc <= r_pc + 1'b1;

            if ((r_state == S_WAIT_I) || (r_state == S_WAIT_D))
                r_lat <= w_lat_last ? 2'd0 : r_lat + 2'd1;
            else
                r_lat <= 2'd0;

            if ((r_state == S_WAIT_I) && w_lat_last)
                r_ir <= MemData;
            if ((r_state == S_WAIT_D) && w_lat_last)
                r_imm <= MemData;

            if (w_next == S_ISSUE)
                r_to <= '0;
            else if ((r_state == S_ISSUE) || (r_state == S_EXEC))
                r_to <= w_to_inc;

            if ((r_state == S_EXEC) && Done && (r_retired != 8'hFF))
                r_retired <= r_retired + 8'd1;
        end
    end

    assign MemAddr = r_pc;
    assign PC      = r_pc;
    assign MemRead = r_memread;
    assign Run     = r_run;
    assign DIN     = r_din;
    assign Retired = r_retired;
    assign Busy    = (r_state != S_IDLE) && (r_state != S_FAULT);
    assign Fault   = (r_state == S_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_sequencer
//  Description : Self-checking bench for fetch_sequencer. Instance A uses the
//                default parameters (5-bit address, latency 1); instance B
//                uses a 2-bit address and latency 3. Expected reads and issues
//                are queued by the stimulus and popped by a monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    typedef struct {
        logic [8:0] run;
        logic [8:0] exec;
    } issue_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A signals
    logic       Reset_a, Enable_a, Done_a;
    logic [4:0] MemAddr_a, PC_a;
    logic       MemRead_a, Run_a, Busy_a, Fault_a;
    logic [8:0] MemData_a, DIN_a;
    logic [7:0] Retired_a;
    // Instance B signals
    logic       Reset_b, Enable_b, Done_b;
    logic [1:0] MemAddr_b, PC_b;
    logic       MemRead_b, Run_b, Busy_b, Fault_b;
    logic [8:0] MemData_b, DIN_b;
    logic [7:0] Retired_b;

    fetch_sequencer #(.ADDR_WIDTH(5), .MEM_LATENCY(1), .START_ADDR(0), .TIMEOUT(8)) dut_a (
        .Clock(clk), .Reset(Reset_a), .Enable(Enable_a),
        .MemAddr(MemAddr_a), .MemRead(MemRead_a), .MemData(MemData_a),
        .DIN(DIN_a), .Run(Run_a), .Done(Done_a), .PC(PC_a),
        .Busy(Busy_a), .Fault(Fault_a), .Retired(Retired_a)
    );

    fetch_sequencer #(.ADDR_WIDTH(2), .MEM_LATENCY(3), .START_ADDR(0), .TIMEOUT(8)) dut_b (
        .Clock(clk), .Reset(Reset_b), .Enable(Enable_b),
        .MemAddr(MemAddr_b), .MemRead(MemRead_b), .MemData(MemData_b),
        .DIN(DIN_b), .Run(Run_b), .Done(Done_b), .PC(PC_b),
        .Busy(Busy_b), .Fault(Fault_b), .Retired(Retired_b)
    );

    // Program memories; MemData shows garbage except on the valid cycle.
    logic [8:0] mem_a [0:31];
    logic [8:0] mem_b [0:3];
    logic       va;
    logic [4:0] aa;
    logic       vb [0:2];
    logic [1:0] ab [0:2];

    always @(posedge clk) begin
        va    <= MemRead_a;
        aa    <= MemAddr_a;
        vb[0] <= MemRead_b;
        ab[0] <= MemAddr_b;
        vb[1] <= vb[0];
        ab[1] <= ab[0];
        vb[2] <= vb[1];
        ab[2] <= ab[1];
    end
    assign MemData_a = (va === 1'b1)    ? mem_a[aa]    : 9'h1FF;
    assign MemData_b = (vb[2] === 1'b1) ? mem_b[ab[2]] : 9'h1FF;

    int     n_tests = 0;
    int     n_fail  = 0;
    int     rdq_a[$];
    int     rdq_b[$];
    issue_t runq_a[$];
    issue_t runq_b[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got event with value 0x%0h, required no event", name, act);
    endtask

    task automatic monitor();
        logic [8:0] exp_a = 9'd0;
        logic [8:0] exp_b = 9'd0;
        bit         pend_a = 1'b0;
        bit         pend_b = 1'b0;
        issue_t     e;
        forever begin
            @(negedge clk);
            if (pend_a) begin chk("A_exec_DIN", DIN_a, exp_a); pend_a = 1'b0; end
            if (pend_b) begin chk("B_exec_DIN", DIN_b, exp_b); pend_b = 1'b0; end
            if (MemRead_a) begin
                if (rdq_a.size() == 0) unexpected("A_read", MemAddr_a);
                else chk("A_read_addr", MemAddr_a, rdq_a.pop_front());
            end
            if (MemRead_b) begin
                if (rdq_b.size() == 0) unexpected("B_read", MemAddr_b);
                else chk("B_read_addr", MemAddr_b, rdq_b.pop_front());
            end
            if (Run_a) begin
                if (runq_a.size() == 0) unexpected("A_run", DIN_a);
                else begin
                    e = runq_a.pop_front();
                    chk("A_run_DIN", DIN_a, e.run);
                    exp_a = e.exec; pend_a = 1'b1;
                end
            end
            if (Run_b) begin
                if (runq_b.size() == 0) unexpected("B_run", DIN_b);
                else begin
                    e = runq_b.pop_front();
                    chk("B_run_DIN", DIN_b, e.run);
                    exp_b = e.exec; pend_b = 1'b1;
                end
            end
        end
    endtask

    task automatic wait_run_b(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (Run_b) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    bit ok;

    initial begin
        for (int i = 0; i < 32; i++) mem_a[i] = 9'o000;
        mem_a[0] = 9'o012;           // mv R1,R2
        mem_a[1] = 9'o130;           // mvi R3
        mem_a[2] = 9'h05A;           // immediate
        mem_a[3] = 9'o045;           // non-mvi, used for the timeout
        mem_b[0] = 9'o012;
        mem_b[1] = 9'o234;
        mem_b[2] = 9'o345;
        mem_b[3] = 9'o456;

        Reset_a = 1'b1; Enable_a = 1'b0; Done_a = 1'b0;
        Reset_b = 1'b1; Enable_b = 1'b0; Done_b = 1'b0;
        fork monitor(); join_none
        @(negedge clk); @(negedge clk);

        // Reset state
        chk("rst_Busy", Busy_a, 0);
        chk("rst_Fault", Fault_a, 0);
        chk("rst_PC", PC_a, 0);
        chk("rst_MemAddr", MemAddr_a, 0);
        chk("rst_DIN", DIN_a, 0);
        chk("rst_Run", Run_a, 0);
        chk("rst_MemRead", MemRead_a, 0);
        chk("rst_Retired", Retired_a, 0);
        chk("rst_B_PC", PC_b, 0);

        // mv then mvi; Enable dropped while the mvi is being fetched
        rdq_a.push_back(0); rdq_a.push_back(1); rdq_a.push_back(2);
        runq_a.push_back('{9'o012, 9'd0});
        runq_a.push_back('{9'o130, 9'h05A});
        Reset_a = 1'b0; Reset_b = 1'b0;
        Enable_a = 1'b1;                                       // cycle 0
        @(negedge clk); chk("T1_read_c1", MemRead_a, 1);       // cycle 1
        @(negedge clk); chk("T1_pc_c2", PC_a, 1);              // cycle 2
                        chk("T1_norun_c2", Run_a, 0);
        @(negedge clk); chk("T1_run_c3", Run_a, 1);            // cycle 3
        @(negedge clk); Done_a = 1'b1;                         // cycle 4
        @(negedge clk); Done_a = 1'b0;                         // cycle 5
                        chk("T1_retired", Retired_a, 1);
                        chk("T1_pc_after", PC_a, 1);
                        chk("T1_next_read_c5", MemRead_a, 1);
                        Enable_a = 1'b0;
        repeat (4) @(negedge clk);                             // cycle 9
        chk("T2_run_c9", Run_a, 1);
        Done_a = 1'b1;                                         // ignored in ISSUE
        @(negedge clk); Done_a = 1'b0;                         // cycle 10
                        chk("T2_issue_done_ignored", Retired_a, 1);
        @(negedge clk); chk("T2_exec_DIN_hold", DIN_a, 9'h05A);// cycle 11
                        Done_a = 1'b1;
        @(negedge clk); Done_a = 1'b0;                         // cycle 12
                        chk("T2_retired", Retired_a, 2);
                        chk("T2_idle", Busy_a, 0);
                        chk("T2_pc", PC_a, 3);
        repeat (2) @(negedge clk);

        // Timeout: Done never arrives
        rdq_a.push_back(3);
        runq_a.push_back('{9'o045, 9'd0});
        Enable_a = 1'b1;
        repeat (3) @(negedge clk); chk("T4_run", Run_a, 1);    // R
        repeat (7) @(negedge clk);                             // R+7
        chk("T4_nofault_r7", Fault_a, 0);
        chk("T4_busy_r7", Busy_a, 1);
        @(negedge clk);                                        // R+8
        chk("T4_fault_r8", Fault_a, 1);
        chk("T4_notbusy_r8", Busy_a, 0);
        for (int i = 0; i < 6; i++) begin
            Enable_a = i[0];
            Done_a   = ~i[0];
            @(negedge clk);
        end
        chk("T4_fault_sticky", Fault_a, 1);
        chk("T4_pc_frozen", PC_a, 4);
        chk("T4_din_zero", DIN_a, 0);
        chk("T4_retired_same", Retired_a, 2);
        Reset_a = 1'b1; Enable_a = 1'b0; Done_a = 1'b0;
        @(negedge clk); Reset_a = 1'b0;
        chk("T4_reset_fault", Fault_a, 0);
        chk("T4_reset_pc", PC_a, 0);
        chk("T4_reset_retired", Retired_a, 0);

        // Done on the last allowed EXEC cycle is a success
        rdq_a.push_back(0);
        runq_a.push_back('{9'o012, 9'd0});
        Enable_a = 1'b1;
        repeat (3) @(negedge clk); chk("TB_run", Run_a, 1);    // R
        Enable_a = 1'b0;
        repeat (7) @(negedge clk);                             // R+7
        chk("TB_nofault_r7", Fault_a, 0);
        Done_a = 1'b1;
        @(negedge clk); Done_a = 1'b0;                         // R+8
        chk("TB_nofault_r8", Fault_a, 0);
        chk("TB_idle", Busy_a, 0);
        chk("TB_retired", Retired_a, 1);

        // Reset during WAIT_D of an mvi; a late Done is ignored
        rdq_a.push_back(1); rdq_a.push_back(2);
        Enable_a = 1'b1;
        repeat (4) @(negedge clk);                             // WAIT_D
        chk("T6_busy_waitd", Busy_a, 1);
        chk("T6_pc_waitd", PC_a, 3);
        Reset_a = 1'b1; Enable_a = 1'b0;
        @(negedge clk);
        chk("T6_idle", Busy_a, 0);
        chk("T6_run", Run_a, 0);
        chk("T6_din", DIN_a, 0);
        chk("T6_pc", PC_a, 0);
        chk("T6_retired", Retired_a, 0);
        chk("T6_memread", MemRead_a, 0);
        Reset_a = 1'b0; Done_a = 1'b1;
        repeat (2) @(negedge clk);
        Done_a = 1'b0;
        chk("T6_late_done", Retired_a, 0);
        chk("T6_still_idle", Busy_a, 0);

        // Instance B: latency 3, PC wrap, stop during EXEC
        for (int i = 0; i < 5; i++) begin
            rdq_b.push_back(i % 4);
            runq_b.push_back('{mem_b[i % 4], 9'd0});
        end
        Enable_b = 1'b1;                                       // cycle 0
        @(negedge clk); chk("T3_read_c1", MemRead_b, 1);
        @(negedge clk); chk("T3_pc_c2", PC_b, 1);
        repeat (2) @(negedge clk); chk("T3_norun_c4", Run_b, 0);
        @(negedge clk); chk("T3_run_c5", Run_b, 1);
        for (int i = 0; i < 5; i++) begin
            wait_run_b(ok);
            chk("T5_run_seen", {31'd0, ok}, 1);
            chk("T5_pc_at_run", PC_b, (i + 1) % 4);
            @(negedge clk);
            if (i == 4) Enable_b = 1'b0;
            Done_b = 1'b1;
            @(negedge clk); Done_b = 1'b0;
        end
        chk("T5_idle", Busy_b, 0);
        chk("T5_retired", Retired_b, 5);
        chk("T5_nofault", Fault_b, 0);
        repeat (6) @(negedge clk);
        chk("T5_stays_idle", Busy_b, 0);

        chk("A_queues_drained", rdq_a.size() + runq_a.size(), 0);
        chk("B_queues_drained", rdq_b.size() + runq_b.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
